recv_byte: RTL
==============

// Module: recv_byte
// PURPOSE
//  UART receiver, 8N1, LSB first; the receive-side counterpart of the byte transmitter.
//  Synchronises the asynchronous uart_rx line and validates the start bit at mid-bit.
//  Samples each bit at its centre, checks the stop bit, then presents the byte with a 1-cycle rx_done.
//  Sits between the board RX pin and the command/loopback logic on sys_clk (50 MHz).
// PARAMETERS
//  DIV_4800    10416  clocks per bit, time_set=0
//  DIV_9600    5208   clocks per bit, time_set=1
//  DIV_115200  434    clocks per bit, time_set=2 and all other codes
//  SYNC_STAGES 2      flip-flops in the uart_rx synchroniser (>=2)
// PORTS
//  sys_clk    in   1  system clock, all logic on posedge
//  rst_n      in   1  asynchronous active-low reset
//  time_set   in   3  baud select (0:4800, 1:9600, 2:115200, others:115200)
//  uart_rx    in   1  serial input, idle high, asynchronous to sys_clk
//  data       out  8  last correctly received byte, held until the next good frame
//  rx_done    out  1  1-cycle pulse: data updated this cycle
//  frame_err  out  1  1-cycle pulse: stop bit sampled low, byte discarded
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - synchroniser and edge register set to 1; state=IDLE.
//   - counters, shift register, data, rx_done and frame_err all cleared to 0.
//  Synchroniser: SYNC_STAGES flops, then one edge register. A falling edge is rx_s_d=1 and rx_s=0.
//  Divider: div is latched from time_set on start-edge detection and stays fixed for the frame.
//   - A time_set change mid-frame has no effect until the next frame.
//  bit_cnt: 32-bit, runs 0..div-1 and wraps. bit_idx: 4-bit, counts 0..7.
//  FSM (4 states):
//   IDLE : bit_cnt=0. On falling edge: latch div, go START.
//   START: count to div/2-1 (integer half).
//          At that point, rx_s=1 (glitch) -> IDLE with no pulse; rx_s=0 -> DATA with bit_cnt=0, bit_idx=0.
//   DATA : at bit_cnt==div-1, shift rx_s into shreg[7] (right shift, so LSB first).
//          bit_idx==7 -> STOP; otherwise bit_idx+1. Samples therefore fall at bit centres.
//   STOP : at bit_cnt==div-1, sample rx_s.
//          1 -> data<=shreg, rx_done=1 for one cycle. 0 -> frame_err=1 for one cycle, data unchanged.
//          Either way, go IDLE in the same cycle.
//  Back-to-back frames:
//   - IDLE is re-entered at the stop-bit centre, so a start edge half a bit later is caught. No idle gap is required.
//   - After frame_err the line may still be low. The next frame needs a new falling edge, which requires rx high first.
//  rx_done and frame_err are never high together, and never high for more than 1 cycle.
//  Latency: rx_done rises about 9.5*div + SYNC_STAGES + 2 cycles after the uart_rx start edge, +/-2 cycles.
//  Falling edges seen while not in IDLE are ignored.
//  rst_n asserted mid-frame: immediate return to the reset state; the partial byte is lost and no pulse is issued.
// TESTING
//  1 time_set=2, send 0xA5 -> data=0xA5, one rx_done pulse about 4125 cycles after start, frame_err stays 0.
//  2 time_set=2, uart_rx low 100 cycles then high -> FSM returns to IDLE, no rx_done or frame_err, data unchanged.
//  3 time_set=2, 0x3C with stop bit forced 0 -> frame_err pulse, rx_done=0, data keeps the previous byte.
//  4 time_set=2, 0x00 then 0xFF with no idle gap between frames -> two rx_done pulses, data 0x00 then 0xFF.
//  5 time_set=0 and time_set=1, send 0x55 -> data=0x55 each time. Also: baud period mismatched by +/-2% -> 0x55 still received.
//  6 rst_n pulsed low mid-frame (bit 4), then 0x81 -> outputs 0 during reset, no stray pulse, then data=0x81 with rx_done.
//  7 loopback from the byte transmitter, 256 random bytes at all three time_set values -> every byte matches.

Source files
------------

// File: rtl/recv_byte_if.sv
// Receiver-side bus for recv_byte: serial line and baud select in, byte and status pulses out.
// Signalling: there is no valid/ready back-pressure. rx_done is a single-cycle
// strobe qualifying data in the same cycle (data then holds until the next good
// frame); frame_err is a single-cycle strobe for a discarded frame. The two
// strobes are never high together. state_dbg mirrors the receiver FSM.
interface recv_byte_if;
  logic [2:0] time_set;
  logic       uart_rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic [1:0] state_dbg;

  modport master (
    output time_set,
    output uart_rx,
    input  data,
    input  rx_done,
    input  frame_err,
    input  state_dbg
  );

  modport slave (
    input  time_set,
    input  uart_rx,
    output data,
    output rx_done,
    output frame_err,
    output state_dbg
  );
endinterface

// File: rtl/recv_byte.sv
// UART 8N1 receiver, LSB first. Synchronises uart_rx, validates the start bit
// at mid-bit, samples every data bit at its centre and checks the stop bit.
module recv_byte #(
  parameter int unsigned DIV_4800    = 10416,
  parameter int unsigned DIV_9600    = 5208,
  parameter int unsigned DIV_115200  = 434,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic       sys_clk,
  input logic       rst_n,
  recv_byte_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s_d_q, rx_s_d_d;
  logic [31:0]            div_q, div_d;
  logic [31:0]            bit_cnt_q, bit_cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [7:0]             data_q, data_d;
  logic                   rx_done_q, rx_done_d;
  logic                   frame_err_q, frame_err_d;

  logic                   rx_s;
  logic                   fall;
  logic [31:0]            div_sel;

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_s_d_q & ~rx_s;

  // Shift the raw line through the synchroniser, then keep one delayed copy for edge detection.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], bus.uart_rx};
    rx_s_d_d = rx_s;
  end

  // Map the baud select code to a clocks-per-bit divider; unknown codes fall back to the fastest rate.
  always_comb begin
    div_sel = DIV_115200;
    case (bus.time_set)
      3'd0:    div_sel = DIV_4800;
      3'd1:    div_sel = DIV_9600;
      default: div_sel = DIV_115200;
    endcase
  end

  // Frame FSM: next state, bit timing, shifting and the one-cycle status strobes.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_cnt_d   = bit_cnt_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        bit_cnt_d = 32'd0;
        if (fall) begin
          // Divider is frozen here so a mid-frame baud change cannot corrupt the byte.
          div_d   = div_sel;
          state_d = START;
        end
      end
      START: begin
        if (bit_cnt_q == (div_q >> 1) - 32'd1) begin
          bit_cnt_d = 32'd0;
          bit_idx_d = 4'd0;
          // A line that is high again at mid start bit was a glitch, not a frame.
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + 32'd1;
        end
      end
      DATA: begin
        if (bit_cnt_q == div_q - 32'd1) begin
          bit_cnt_d = 32'd0;
          shreg_d   = {rx_s, shreg_q[7:1]};
          if (bit_idx_q == 4'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 32'd1;
        end
      end
      STOP: begin
        if (bit_cnt_q == div_q - 32'd1) begin
          bit_cnt_d = 32'd0;
          // Returning to IDLE at the stop-bit centre lets a back-to-back start edge be caught.
          state_d   = IDLE;
          if (rx_s) begin
            data_d    = shreg_q;
            rx_done_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; the synchroniser resets to the idle-high line level.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= '1;
      rx_s_d_q    <= 1'b1;
      div_q       <= 32'd0;
      bit_cnt_q   <= 32'd0;
      bit_idx_q   <= 4'd0;
      shreg_q     <= 8'd0;
      data_q      <= 8'd0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      rx_s_d_q    <= rx_s_d_d;
      div_q       <= div_d;
      bit_cnt_q   <= bit_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.data      = data_q;
  assign bus.rx_done   = rx_done_q;
  assign bus.frame_err = frame_err_q;
  assign bus.state_dbg = state_q;

endmodule
